// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, multi-cycle controller states and the
// select/class codes driven onto the datapath muxes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // ALU operation class; funct decoding happens in the ALU control block.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing a shared ALU and a
// unified memory, with memory-ready stalls, illegal-opcode trap and retire counter.
module mc_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             mem_read,
  output logic             MemWrite,
  output logic             ir_write,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             wea_reg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOP,
  output logic             ExtOp,
  output logic [1:0]       PCSource,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             pc_en_raw, ir_write_raw, wea_raw, mem_write_raw;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      // Later states decode the latched copy, so IR changes after DECODE are harmless.
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d == S_TRAP) halted_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_en_raw     = 1'b0;
    ir_write_raw  = 1'b0;
    wea_raw       = 1'b0;
    mem_write_raw = 1'b0;
    IorD          = 1'b0;
    mem_read      = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    ALUOP         = ALUOP_ADD;
    ExtOp         = 1'b0;
    PCSource      = PCSRC_ALU;
    retire        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read     = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        ExtOp   = 1'b1;
        case (opcode)
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_RTYPE:                           state_d = S_R_EXEC;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_I_EXEC;
          default:                            state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtOp   = 1'b1;
        state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        wea_raw  = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOP   = ALUOP_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        wea_raw = 1'b1;
        RegDst  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOP     = ALUOP_SUB;
        PCSource  = PCSRC_ALUOUT;
        pc_en_raw = (op_q == OP_BNE) ? ~zero : zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        PCSource  = PCSRC_JUMP;
        pc_en_raw = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOP   = ALUOP_IMM;
        // Logical immediates are zero-extended; arithmetic/compare ones sign-extended.
        ExtOp   = !((op_q == OP_ANDI) || (op_q == OP_ORI));
        state_d = S_I_WB;
      end
      S_I_WB: begin
        wea_raw = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Architectural write enables are suppressed during the reset cycle itself.
  assign pc_en       = pc_en_raw & ~rst;
  assign ir_write    = ir_write_raw & ~rst;
  assign wea_reg     = wea_raw & ~rst;
  assign MemWrite    = mem_write_raw & ~rst;
  assign halted      = halted_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
